regbank_write_demux: RTL and testbench

//  Write side of the register bank: the 1-to-N counterpart of the read-select muxes.
//  - Accepts one register write per cycle over a valid/ready handshake.
//  - Holds the request in a one-entry stage.
//  - Decodes the address to a one-hot write strobe and updates the register array.
//  - Exposes the whole array flattened, for the read muxes to select from.

---
 rtl/regbank_write_demux_if.sv | 12 +
 rtl/regbank_write_demux.sv | 58 +++++
 tb/tb_regbank_write_demux.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regbank_write_demux_if.sv
// regbank_write_demux_if: valid/ready register-write request channel.
interface regbank_write_demux_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    modport master(output valid, addr, data, input ready);
    modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/regbank_write_demux.sv
// regbank_write_demux: one-entry write stage decoding into a one-hot strobe over the register array.
module regbank_write_demux #(
    parameter int NREGS    = 8,
    parameter int AW       = 3,
    parameter int DW       = 32,
    parameter bit ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    regbank_write_demux_if.slave   i_wr,
    input  logic                   i_commit_stall,
    output logic [NREGS-1:0]       o_wr_en_onehot,
    output logic [NREGS*DW-1:0]    o_regs_flat,
    output logic                   o_busy,
    output logic                   o_err_addr
);
    typedef enum logic {EMPTY, PEND} state_t;
    state_t        r_state, w_next;
    logic [AW-1:0] r_hold_addr;
    logic [DW-1:0] r_hold_data;
    logic          r_err_addr;
    logic [DW-1:0] r_regs [NREGS];
    logic          w_accept, w_commit, w_oor;
    assign i_wr.ready = (r_state == EMPTY) | !i_commit_stall;
    assign w_accept   = i_wr.valid & i_wr.ready;
    assign w_commit   = (r_state == PEND) & !i_commit_stall;
    assign w_oor      = 32'(i_wr.addr) >= 32'(NREGS);
    assign o_busy     = r_state == PEND;
    assign o_err_addr = r_err_addr;
    always_comb begin
        w_next = r_state;
        w_next = w_accept ? PEND : (w_commit ? EMPTY : r_state);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_hold_addr <= '0;
            r_hold_data <= '0;
            r_err_addr  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_err_addr <= w_accept & w_oor;
            if (w_accept) begin
                r_hold_addr <= i_wr.addr;
                r_hold_data <= i_wr.data;
            end
        end
    end
    // out-of-range addresses match no lane, so they pass through without a strobe
    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        assign o_wr_en_onehot[g] = w_commit && (r_hold_addr == AW'(g)) && !(ZERO_REG && g == 0);
        assign o_regs_flat[g*DW +: DW] = r_regs[g];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_regs[g] <= '0;
            else if (o_wr_en_onehot[g]) r_regs[g] <= r_hold_data;
        end
    end
endmodule

// File: tb/tb_regbank_write_demux.sv
// tb_regbank_write_demux: directed checks of the write stage with NREGS=8 and NREGS=6 instances.
module tb_regbank_write_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall8 = 1'b0, stall6 = 1'b0;
    logic [7:0]   en8;
    logic [5:0]   en6;
    logic [255:0] flat8;
    logic [191:0] flat6;
    logic busy8, busy6, err8, err6;
    int checks = 0;
    int failures = 0;
    regbank_write_demux_if #(.AW(3), .DW(32)) if8 ();
    regbank_write_demux_if #(.AW(3), .DW(32)) if6 ();
    regbank_write_demux #(.NREGS(8)) dut8 (
        .clk(clk), .rst(rst), .i_wr(if8.slave), .i_commit_stall(stall8),
        .o_wr_en_onehot(en8), .o_regs_flat(flat8), .o_busy(busy8), .o_err_addr(err8)
    );
    regbank_write_demux #(.NREGS(6)) dut6 (
        .clk(clk), .rst(rst), .i_wr(if6.slave), .i_commit_stall(stall6),
        .o_wr_en_onehot(en6), .o_regs_flat(flat6), .o_busy(busy6), .o_err_addr(err6)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic drv8(input logic v, input logic [2:0] a, input logic [31:0] d);
        if8.valid = v;
        if8.addr  = a;
        if8.data  = d;
    endtask
    task automatic drv6(input logic v, input logic [2:0] a, input logic [31:0] d);
        if6.valid = v;
        if6.addr  = a;
        if6.data  = d;
    endtask
    logic [2:0]  b2b_addr [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [31:0] b2b_data [4] = '{32'h1111_0001, 32'h2222_0002, 32'h5555_0005, 32'h7777_0007};
    initial begin
        drv8(1'b0, 3'd0, 32'd0);
        drv6(1'b0, 3'd0, 32'd0);
        // reset state
        @(negedge clk);
        #1;
        chk("rst_regs", flat8, '0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_ready", if8.ready, 1'b1);
        chk("rst_strobe", en8, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        // single write
        @(negedge clk);
        drv8(1'b1, 3'd3, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", if8.ready, 1'b1);
        @(negedge clk);
        drv8(1'b0, 3'd0, 32'd0);
        #1;
        chk("single_strobe", en8, 8'b0000_1000);
        chk("single_busy", busy8, 1'b1);
        chk("single_reg_before", flat8[3*32 +: 32], 32'd0);
        @(negedge clk);
        #1;
        chk("single_reg", flat8[3*32 +: 32], 32'hDEAD_BEEF);
        chk("single_strobe_off", en8, 8'h00);
        chk("single_idle", busy8, 1'b0);
        // back-to-back writes, strobe trails the offer by one cycle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) drv8(1'b1, b2b_addr[i], b2b_data[i]);
            else drv8(1'b0, 3'd0, 32'd0);
            #1;
            chk("b2b_ready", if8.ready, 1'b1);
            if (i > 0) chk("b2b_strobe", en8, 256'(8'(1) << b2b_addr[i-1]));
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk("b2b_reg", flat8[32*b2b_addr[i] +: 32], b2b_data[i]);
        chk("b2b_keep3", flat8[3*32 +: 32], 32'hDEAD_BEEF);
        // stall for three cycles; a request offered while not ready must be ignored
        drv8(1'b1, 3'd4, 32'h55);
        @(negedge clk);
        drv8(1'b1, 3'd6, 32'h66);
        stall8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", if8.ready, 1'b0);
            chk("stall_strobe", en8, 8'h00);
            chk("stall_reg", flat8[4*32 +: 32], 32'd0);
            @(negedge clk);
        end
        stall8 = 1'b0;
        drv8(1'b0, 3'd0, 32'd0);
        #1;
        chk("stall_commit", en8, 8'b0001_0000);
        chk("stall_ready_back", if8.ready, 1'b1);
        @(negedge clk);
        #1;
        chk("stall_reg4", flat8[4*32 +: 32], 32'h55);
        chk("stall_ignored6", flat8[6*32 +: 32], 32'd0);
        chk("stall_idle", busy8, 1'b0);
        // zero register and out-of-range on the 6-register instance
        drv6(1'b1, 3'd0, 32'hFFFF);
        @(negedge clk);
        drv6(1'b1, 3'd7, 32'h77);
        #1;
        chk("zero_strobe", en6, 6'h00);
        chk("zero_busy", busy6, 1'b1);
        chk("zero_no_err", err6, 1'b0);
        @(negedge clk);
        drv6(1'b0, 3'd0, 32'd0);
        #1;
        chk("oor_strobe", en6, 6'h00);
        chk("oor_err", err6, 1'b1);
        chk("oor_busy", busy6, 1'b1);
        @(negedge clk);
        #1;
        chk("oor_err_once", err6, 1'b0);
        chk("oor_idle", busy6, 1'b0);
        chk("zero_regs6", flat6, '0);
        // reset while a write is stalled
        drv8(1'b1, 3'd2, 32'h22);
        @(negedge clk);
        drv8(1'b0, 3'd0, 32'd0);
        stall8 = 1'b1;
        #1;
        chk("rstmid_busy", busy8, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid_regs", flat8, '0);
        chk("rstmid_busy_clr", busy8, 1'b0);
        chk("rstmid_ready", if8.ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        stall8 = 1'b0;
        #1;
        chk("rstmid_no_strobe", en8, 8'h00);
        @(negedge clk);
        #1;
        chk("rstmid_reg2", flat8[2*32 +: 32], 32'd0);
        chk("rstmid_no_strobe2", en8, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
